// File: rtl/kernel_result_writer_if.sv
// Pixel stream input and output frame RAM write bus
// for the kernel result writer.
interface kernel_result_writer_if #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_ack;

  modport master (
    output in_valid,
    output in_data,
    output wr_ack,
    input  in_ready,
    input  wr_address,
    input  wr_data,
    input  wr_en
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  wr_ack,
    output in_ready,
    output wr_address,
    output wr_data,
    output wr_en
  );
endinterface

// File: rtl/kernel_result_writer.sv
// Clamps kernel results, buffers them in a small FIFO
// and writes them row-major into the output frame RAM.
module kernel_result_writer #(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 17,
  parameter int PIX_MAX    = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  kernel_result_writer_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pix_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] TOTAL =
    CW'(IMG_W * IMG_H);
  localparam logic [DATA_W-1:0] MAXV =
    DATA_W'(PIX_MAX);
  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0]       wp;
  logic [PW:0]       rp;
  logic [CW-1:0]     acc_cnt;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr;
  logic              run;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              last;
  logic              neg;
  logic              big;
  logic [DATA_W-1:0] clamped;

  assign run   = (state == RUN);
  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);

  // Space freed by a pop is only seen next cycle,
  // keeping wr_ack out of the in_ready path.
  assign bus.in_ready = run && !full &&
                        (acc_cnt < TOTAL);
  assign bus.wr_en    = run && !empty;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.wr_en && bus.wr_ack;
  assign last = (cnt == TOTAL - CW'(1));

  assign bus.wr_data    = empty ? '0
                        : mem[rp[PW-1:0]];
  assign bus.wr_address = addr;
  assign pix_count      = cnt;
  assign busy           = run;
  assign done           = (state == DONE);

  assign neg = bus.in_data[DATA_W-1];
  assign big = !neg && (bus.in_data > MAXV);

  always_comb begin
    clamped = bus.in_data;
    unique case (1'b1)
      neg:     clamped = '0;
      big:     clamped = MAXV;
      default: clamped = bus.in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[PW-1:0]] <= clamped;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      wp      <= '0;
      rp      <= '0;
      acc_cnt <= '0;
      cnt     <= '0;
      addr    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            wp      <= '0;
            rp      <= '0;
            acc_cnt <= '0;
            cnt     <= '0;
            addr    <= '0;
          end
        end
        RUN: begin
          if (push) begin
            wp      <= wp + (PW+1)'(1);
            acc_cnt <= acc_cnt + CW'(1);
          end
          if (pop) begin
            rp  <= rp + (PW+1)'(1);
            cnt <= cnt + CW'(1);
            // Saturate rather than wrap past the top.
            if (addr != ADDR_TOP)
              addr <= addr + ADDR_W'(1);
            if (last) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_result_writer.sv
// Directed bench for kernel_result_writer on a 4x2
// frame with a 4-entry FIFO.
module tb_kernel_result_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 17;

  logic            clk;
  logic            n_rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [ADDR_W:0] pix_count;

  kernel_result_writer_if #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) bus ();

  kernel_result_writer #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PIX_MAX(255),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .bus(bus),
    .busy(busy),
    .done(done),
    .pix_count(pix_count)
  );

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
  } vec_t;

  vec_t tbl [8];
  int   n_tests;
  int   n_fail;
  int   acc;
  int   wrs;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_rst   = 1'b0;
    start   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wr_ack   = 1'b0;

    tbl[0] = '{17'h1FFFF, 17'd0};
    tbl[1] = '{17'd300,   17'd255};
    tbl[2] = '{17'd255,   17'd255};
    tbl[3] = '{17'd0,     17'd0};
    tbl[4] = '{17'd17,    17'd17};
    tbl[5] = '{17'h10000, 17'd0};
    tbl[6] = '{17'd256,   17'd255};
    tbl[7] = '{17'h0FFFF, 17'd255};

    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_address", bus.wr_address, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_count", pix_count, 0);

    step();
    step();
    n_rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 17'd5;
    step();
    step();
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_wr_en", bus.wr_en, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_pix_count", pix_count, 0);

    // Frame 1: clamp table, streaming writes
    bus.in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("f1_busy", busy, 1);
    check("f1_in_ready", bus.in_ready, 1);
    bus.wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("clamp_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = tbl[i].din;
      step();
      check("clamp_wr_en", bus.wr_en, 1);
      check("clamp_data", bus.wr_data, tbl[i].dout);
      check("clamp_addr", bus.wr_address, i);
    end
    check("f1_full_frame_rdy", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    step();
    check("f1_done", done, 1);
    check("f1_busy_end", busy, 0);
    check("f1_pix_count", pix_count, 8);
    check("f1_wr_en_end", bus.wr_en, 0);
    check("f1_addr_end", bus.wr_address, 8);

    // Frame 2: restart, overfeed, mid-run start
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_done", done, 0);
    check("rs_busy", busy, 1);
    check("rs_addr", bus.wr_address, 0);
    check("rs_pix_count", pix_count, 0);
    acc = 0;
    wrs = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.in_data = DATA_W'(20 + acc);
      start = (c == 3);
      if (bus.wr_en) begin
        check("fe_addr", bus.wr_address, wrs);
        check("fe_data", bus.wr_data, 20 + wrs);
      end
      if (bus.in_ready) acc++;
      if (bus.wr_en && bus.wr_ack) wrs++;
      step();
      start = 1'b0;
    end
    check("fe_done", done, 1);
    check("fe_accepts", acc, 8);
    check("fe_writes", wrs, 8);
    check("fe_pix_count", pix_count, 8);
    check("fe_addr_hold", bus.wr_address, 8);
    check("fe_in_ready", bus.in_ready, 0);

    // Frame 3: backpressure, then async reset
    start = 1'b1;
    step();
    start = 1'b0;
    bus.wr_ack = 1'b0;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      check("bp_ready", bus.in_ready, c < 4);
      bus.in_data = DATA_W'(10 + acc);
      if (bus.in_ready) acc++;
      step();
      check("bp_wr_en", bus.wr_en, 1);
      check("bp_addr", bus.wr_address, 0);
      check("bp_data", bus.wr_data, 10);
    end
    check("bp_accepts", acc, 4);
    bus.in_data = 17'd14;
    bus.wr_ack  = 1'b1;
    step();
    check("dr_data0", bus.wr_data, 11);
    check("dr_addr0", bus.wr_address, 1);
    check("dr_ready", bus.in_ready, 1);
    step();
    check("dr_data1", bus.wr_data, 12);
    bus.in_valid = 1'b0;
    step();
    check("dr_pix_count", pix_count, 3);
    check("dr_addr", bus.wr_address, 3);
    check("dr_data2", bus.wr_data, 13);
    bus.wr_ack = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("ar_wr_en", bus.wr_en, 0);
    check("ar_addr", bus.wr_address, 0);
    check("ar_data", bus.wr_data, 0);
    check("ar_pix_count", pix_count, 0);
    check("ar_busy", busy, 0);
    check("ar_in_ready", bus.in_ready, 0);
    check("ar_done", done, 0);
    step();
    step();
    n_rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.wr_ack   = 1'b1;
    step();
    check("post_busy", busy, 0);
    check("post_wr_en", bus.wr_en, 0);
    check("post_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("post_run_busy", busy, 1);
    check("post_run_wr_en", bus.wr_en, 0);
    check("post_run_count", pix_count, 0);
    check("post_run_ready", bus.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kernel_result_writer.md
Name: kernel_result_writer

Overview:
- Write-side counterpart to the kernel window fetch path.
- Accepts the stream of filtered pixels produced by the 3x3 kernel datapath (blur/sharpen/outline/emboss mux output).
- Clamps each pixel to displayable range, buffers it in a small FIFO, and writes it row-major into the output frame RAM.
- Flags frame completion.

Parameters:
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels
- ADDR_W, 16, output RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- DATA_W, 17, pixel/result word width
- PIX_MAX, 255, upper clamp value
- FIFO_DEPTH, 4, buffer entries; power of two, >= 2

Ports:
- clk  input  1  single clock, all logic rising-edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begins a frame
- in_valid  input  1  in_data holds a kernel result
- in_data  input  DATA_W  kernel result, two's complement
- in_ready  output  1  block accepts in_data this cycle
- wr_address  output  ADDR_W  output RAM address
- wr_data  output  DATA_W  clamped pixel to write
- wr_en  output  1  write request
- wr_ack  input  1  RAM accepts write when wr_en & wr_ack
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pix_count  output  ADDR_W+1  number of writes acked this frame

Behaviour:
- Reset (async, n_rst=0): state IDLE; FIFO empty; wr_address=0; wr_data=0; wr_en=0; in_ready=0; busy=0; done=0; pix_count=0; accept counter=0. Reset mid-frame discards FIFO contents and partial frame.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=0, wr_en=0. start -> RUN next cycle; clears wr_address, pix_count, accept counter, FIFO.
  - RUN: busy=1. start ignored.
  - DONE: done=1, in_ready=0, wr_en=0. start -> RUN with same clearing as IDLE. done deasserts in the same cycle busy asserts.
- Accept side:
  - in_ready = (state==RUN) & FIFO not full & (accept counter < IMG_W*IMG_H).
  - Push on in_valid & in_ready; accept counter += 1.
  - A pop in the same cycle does NOT free space for a push. in_ready depends on registered full flag only, with no combinational path from wr_ack.
- Clamp, applied at push:
  - in_data sign bit set -> 0.
  - else in_data > PIX_MAX -> PIX_MAX.
  - else in_data unchanged.
  - Stored value is DATA_W bits, zero-extended.
- Write side:
  - wr_en = FIFO not empty, in RUN.
  - wr_data = FIFO head, wr_address = current address. Both are stable while wr_en=1 and wr_ack=0.
  - On wr_en & wr_ack: pop; wr_address += 1; pix_count += 1.
- Latency: a pushed sample reaches wr_data/wr_en at the earliest 1 cycle after acceptance. Ordering is strictly FIFO.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur; occupancy unchanged.
- Frame end: the ack of write number IMG_W*IMG_H (address IMG_W*IMG_H-1) moves the FSM to DONE next cycle. wr_address holds the last address + 1 without wrapping, until the next start.
- Inputs beyond IMG_W*IMG_H per frame are never accepted (in_ready held 0). in_valid during IDLE/DONE is ignored.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses an extra pointer bit for full/empty disambiguation.

Test Plan:
- All tests use IMG_W=4, IMG_H=2, FIFO_DEPTH=4, PIX_MAX=255.
- Reset then idle: in_valid=1, no start -> in_ready=0, wr_en=0, done=0, all outputs 0.
- Clamp: start, push 17'h1FFFF(-1), 300, 255, 0, 17 with wr_ack=1 -> wr_data sequence 0, 255, 255, 0, 17 at addresses 0..4, each 1 cycle after accept.
- Backpressure: wr_ack=0, push continuously -> in_ready drops after 4 accepts, wr_data/wr_address frozen at addr 0. Then wr_ack=1 -> drains in order; in_ready returns the cycle after the first pop.
- Frame end: push 10 samples, wr_ack=1 -> exactly 8 writes (addresses 0..7), in_ready=0 after 8th accept, done=1 the cycle after 8th ack, pix_count=8.
- Restart: start in DONE -> done=0, busy=1, wr_address=0, pix_count=0; a second full frame writes addresses 0..7 again. A start pulse mid-RUN leaves address/count unchanged.
- Async reset mid-frame: drop n_rst after 3 writes with 2 entries in FIFO -> outputs zero immediately without a clock edge. After release, state IDLE, FIFO empty, no stray wr_en.
